// File: rtl/rob_commit_sched.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_sched
// Brief    : Lite reorder buffer that allocates tags, captures out-of-order
//            CDB results and retires in program order onto the regfile
//            unlock port. Optional statistics via ROB_COMMIT_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_sched #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 4,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic [ROB_W-1:0]  alloc_robpos,
  output logic              alloc_ok,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_robpos,
  input  logic [DATA_W-1:0] cdb_val,
  input  logic              cdb_mispred,
  input  logic [DATA_W-1:0] cdb_target,
  output logic              unlock,
  output logic [REG_W-1:0]  unlock_rd,
  output logic [ROB_W-1:0]  unlock_robpos,
  output logic [DATA_W-1:0] unlock_val,
  output logic              clear,
  output logic [DATA_W-1:0] clear_pc,
`ifdef ROB_COMMIT_STAT_EN
  output logic [31:0]       commit_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              full,
  output logic              empty
);

  localparam logic [ROB_W:0] CNT_FULL = (ROB_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] done;
  logic [ROB_SIZE-1:0] mispred;
  logic [REG_W-1:0]    rd_q     [ROB_SIZE];
  logic [DATA_W-1:0]   val_q    [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];

  logic [ROB_W-1:0] head;
  logic [ROB_W-1:0] tail;
  logic [ROB_W:0]   count;
  logic [ROB_W:0]   count_next;

  logic alloc_fire;
  logic retire_fire;
  logic cdb_fire;

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign alloc_robpos = tail;
  assign alloc_ok     = !full && !clear;

  assign alloc_fire  = ready && alloc_valid && alloc_ok;
  assign retire_fire = ready && busy[head] && done[head] && !clear;
  // CDB writes are accepted regardless of ready, but never during a flush
  assign cdb_fire    = cdb_valid && busy[cdb_robpos] && !clear;

  always_comb begin
    count_next = count;
    case ({alloc_fire, retire_fire})
      2'b10:   count_next = count + (ROB_W+1)'(1);
      2'b01:   count_next = count - (ROB_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= '0;
      done          <= '0;
      mispred       <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      unlock        <= 1'b0;
      unlock_rd     <= '0;
      unlock_robpos <= '0;
      unlock_val    <= '0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else begin
      unlock <= 1'b0;
      clear  <= 1'b0;
      if (clear) begin
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cdb_fire) begin
          done[cdb_robpos]    <= 1'b1;
          mispred[cdb_robpos] <= cdb_mispred;
        end
        if (retire_fire) begin
          busy[head]    <= 1'b0;
          head          <= head + ROB_W'(1);
          unlock        <= |rd_q[head];
          unlock_rd     <= rd_q[head];
          unlock_robpos <= head;
          unlock_val    <= val_q[head];
          clear         <= mispred[head];
          if (mispred[head]) begin
            clear_pc <= target_q[head];
          end
        end
        // A freshly allocated slot is never busy, so it cannot collide with CDB or retire
        if (alloc_fire) begin
          busy[tail]    <= 1'b1;
          done[tail]    <= 1'b0;
          mispred[tail] <= 1'b0;
          tail          <= tail + ROB_W'(1);
        end
        count <= count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_q[tail] <= alloc_rd;
    end
    if (cdb_fire) begin
      val_q[cdb_robpos]    <= cdb_val;
      target_q[cdb_robpos] <= cdb_target;
    end
  end

`ifdef ROB_COMMIT_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (retire_fire && !(&commit_cnt)) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
      if (clear && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
